// File: rtl/cache_ctrl_sa.sv
// cache_ctrl_sa: 2-way set-associative cache controller with per-set LRU and a block-wide memory port.
// `define CACHE_WRITE_BACK_EN for write-back/write-allocate; otherwise write-through/no-allocate.
module cache_ctrl_sa #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int SETS = 2,
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic                    cpu_ready,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_hit,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [WORDS-1:0]        mem_wmask,
  output logic [WORDS*DATA_W-1:0] mem_wdata,
  input  logic [WORDS*DATA_W-1:0] mem_rdata,
  input  logic                    mem_ack
);
  localparam int WB = $clog2(WORDS);
  localparam int OFF = WB + 2;
  localparam int IDX = $clog2(SETS);
  localparam int TAG = ADDR_W - OFF - IDX;
  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, WTHRU, RESPOND} state_t;
  state_t state, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic we_q;
  logic [DATA_W-1:0] wdata_q;
  logic victim_q, victim_d;
  logic [SETS-1:0] valid [2];
  logic [SETS-1:0] lru;
`ifdef CACHE_WRITE_BACK_EN
  logic [SETS-1:0] dirty [2];
`endif
  logic [TAG-1:0] tags [2][SETS];
  logic [WORDS*DATA_W-1:0] blocks [2][SETS];
  logic [IDX-1:0] idx;
  logic [TAG-1:0] tag;
  logic [WB-1:0] word;
  logic hit0, hit1, hit, hway, ack;
  logic [WORDS*DATA_W-1:0] hblock;
  logic [DATA_W-1:0] hword;
  logic latch, upd_word, fill, touch;
  logic ready_d, hit_d, mreq_d, mwe_d;
  logic [DATA_W-1:0] rdata_d;
  logic [ADDR_W-1:0] maddr_d;
  logic [WORDS-1:0] mmask_d;
  logic [WORDS*DATA_W-1:0] mwdata_d;
  logic unused_lsb;
  assign unused_lsb = ^addr_q[1:0];
  assign idx = addr_q[OFF +: IDX];
  assign tag = addr_q[ADDR_W-1 -: TAG];
  assign word = addr_q[2 +: WB];
  assign hit0 = valid[0][idx] && tags[0][idx] == tag;
  assign hit1 = valid[1][idx] && tags[1][idx] == tag;
  assign hit = hit0 | hit1;
  assign hway = hit1;
  assign hblock = blocks[hway][idx];
  assign hword = hblock[word*DATA_W +: DATA_W];
  // an ack only counts while a request is actually outstanding
  assign ack = mem_ack & mem_req;
  always_comb begin
    state_d = state;
    victim_d = victim_q;
    latch = 1'b0;
    upd_word = 1'b0;
    fill = 1'b0;
    touch = 1'b0;
    ready_d = 1'b0;
    hit_d = cpu_hit;
    rdata_d = cpu_rdata;
    mreq_d = 1'b0;
    mwe_d = mem_we;
    maddr_d = mem_addr;
    mmask_d = mem_wmask;
    mwdata_d = mem_wdata;
    case (state)
      IDLE: if (cpu_req && !cpu_ready) begin
        latch = 1'b1;
        hit_d = 1'b1;
        state_d = COMPARE;
      end
      COMPARE: if (hit) begin
        touch = 1'b1;
        upd_word = we_q;
        rdata_d = we_q ? cpu_rdata : hword;
`ifdef CACHE_WRITE_BACK_EN
        state_d = RESPOND;
`else
        state_d = we_q ? WTHRU : RESPOND;
`endif
      end else begin
        hit_d = 1'b0;
        victim_d = !valid[0][idx] ? 1'b0 : !valid[1][idx] ? 1'b1 : lru[idx];
`ifdef CACHE_WRITE_BACK_EN
        state_d = valid[victim_d][idx] && dirty[victim_d][idx] ? WRITEBACK : ALLOCATE;
`else
        state_d = we_q ? WTHRU : ALLOCATE;
`endif
      end
      WRITEBACK: begin
        mreq_d = !ack;
        mwe_d = 1'b1;
        maddr_d = {tags[victim_q][idx], idx, {OFF{1'b0}}};
        mmask_d = '1;
        mwdata_d = blocks[victim_q][idx];
        state_d = ack ? ALLOCATE : WRITEBACK;
      end
      ALLOCATE: begin
        mreq_d = !ack;
        mwe_d = 1'b0;
        maddr_d = {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};
        mmask_d = '0;
        fill = ack;
        state_d = ack ? COMPARE : ALLOCATE;
      end
      WTHRU: begin
        mreq_d = !ack;
        mwe_d = 1'b1;
        maddr_d = {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};
        mmask_d = WORDS'(1) << word;
        mwdata_d = (WORDS*DATA_W)'(wdata_q) << (word * DATA_W);
        state_d = ack ? RESPOND : WTHRU;
      end
      RESPOND: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      victim_q <= 1'b0;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      cpu_hit <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
      valid[0] <= '0;
      valid[1] <= '0;
      lru <= '0;
`ifdef CACHE_WRITE_BACK_EN
      dirty[0] <= '0;
      dirty[1] <= '0;
`endif
    end else begin
      state <= state_d;
      victim_q <= victim_d;
      cpu_ready <= ready_d;
      cpu_rdata <= rdata_d;
      cpu_hit <= hit_d;
      mem_req <= mreq_d;
      mem_we <= mwe_d;
      mem_addr <= maddr_d;
      mem_wmask <= mmask_d;
      mem_wdata <= mwdata_d;
      if (latch) begin
        addr_q <= cpu_addr;
        we_q <= cpu_we;
        wdata_q <= cpu_wdata;
      end
      if (touch) lru[idx] <= ~hway;
      if (fill) valid[victim_q][idx] <= 1'b1;
`ifdef CACHE_WRITE_BACK_EN
      if (fill) dirty[victim_q][idx] <= 1'b0;
      if (upd_word) dirty[hway][idx] <= 1'b1;
`endif
    end
  // block storage survives reset; only the valid bits gate its use
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[victim_q][idx] <= tag;
      blocks[victim_q][idx] <= mem_rdata;
    end
    if (upd_word) blocks[hway][idx][word*DATA_W +: DATA_W] <= wdata_q;
  end
endmodule

// File: tb/tb_cache_ctrl_sa.sv
// tb_cache_ctrl_sa: randomized bench for cache_ctrl_sa against a behavioural cache/memory model.
module tb_cache_ctrl_sa;
  typedef struct packed {
    logic         we;
    logic [9:0]   addr;
    logic [3:0]   mask;
    logic [127:0] data;
  } txn_t;
  logic clk, rst_n, cpu_req, cpu_we, cpu_ready, cpu_hit, mem_req, mem_we, mem_ack;
  logic [9:0] cpu_addr, mem_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic [3:0] mem_wmask;
  logic [127:0] mem_wdata, mem_rdata;
  int n_chk = 0, n_fail = 0;
  logic rsp_en, force_ack;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  bit m_v [2][2];
  bit m_d [2][2];
  bit m_lru [2];
  logic [4:0] m_tag [2][2];
  logic [31:0] m_blk [2][2][4];
  txn_t exp_q[$], got_q[$], last_txn[$];
  logic [31:0] r_rdata;
  logic r_hit;
  int r_lat;
  cache_ctrl_sa dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // memory responder: random ack delay, logs every completed transfer
  initial begin
    int wn;
    txn_t t;
    logic [127:0] blk;
    wn = -1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = force_ack;
      if (!mem_req) wn = -1;
      else if (rsp_en) begin
        if (wn < 0) wn = $urandom_range(0, 3);
        if (wn == 0) begin
          t = '0;
          t.we = mem_we;
          t.addr = mem_addr;
          for (int w = 0; w < 4; w++) blk[32*w +: 32] = mem[int'(mem_addr[9:2]) + w];
          if (mem_we) begin
            t.mask = mem_wmask;
            for (int w = 0; w < 4; w++)
              if (mem_wmask[w]) begin
                mem[int'(mem_addr[9:2]) + w] = mem_wdata[32*w +: 32];
                t.data[32*w +: 32] = mem_wdata[32*w +: 32];
              end
          end
          mem_rdata = blk;
          mem_ack = 1'b1;
          got_q.push_back(t);
          wn = -1;
        end else wn--;
      end
    end
  end
  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int s = 0; s < 2; s++) begin
        m_v[i][s] = 0;
        m_d[i][s] = 0;
      end
    m_lru[0] = 0;
    m_lru[1] = 0;
  endtask
  task automatic push_wr(input logic [9:0] a, input logic [31:0] wd);
    txn_t x;
    x = '0;
    x.we = 1'b1;
    x.addr = {a[9:4], 4'b0};
    x.mask = 4'b1 << a[3:2];
    x.data = 128'(wd) << (32 * int'(a[3:2]));
    ref_mem[int'(a[9:2])] = wd;
    exp_q.push_back(x);
  endtask
  task automatic model(input logic we, input logic [9:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic hit);
    int s, w, way, base;
    logic [4:0] t;
    txn_t x;
    s = int'(a[4]);
    w = int'(a[3:2]);
    t = a[9:5];
    base = int'(a[9:4]) * 4;
    way = -1;
    rd = '0;
    for (int i = 0; i < 2; i++) if (m_v[i][s] && m_tag[i][s] == t) way = i;
    hit = way >= 0;
`ifndef CACHE_WRITE_BACK_EN
    if (!hit && we) begin
      push_wr(a, wd);
      return;
    end
`endif
    if (!hit) begin
      way = !m_v[0][s] ? 0 : !m_v[1][s] ? 1 : int'(m_lru[s]);
`ifdef CACHE_WRITE_BACK_EN
      if (m_v[way][s] && m_d[way][s]) begin
        x = '0;
        x.we = 1'b1;
        x.addr = {m_tag[way][s], a[4], 4'b0};
        x.mask = 4'hf;
        for (int i = 0; i < 4; i++) begin
          x.data[32*i +: 32] = m_blk[way][s][i];
          ref_mem[int'({m_tag[way][s], a[4]}) * 4 + i] = m_blk[way][s][i];
        end
        exp_q.push_back(x);
      end
`endif
      x = '0;
      x.addr = {a[9:4], 4'b0};
      exp_q.push_back(x);
      for (int i = 0; i < 4; i++) m_blk[way][s][i] = ref_mem[base + i];
      m_v[way][s] = 1;
      m_d[way][s] = 0;
      m_tag[way][s] = t;
    end
    if (we) begin
      m_blk[way][s][w] = wd;
`ifdef CACHE_WRITE_BACK_EN
      m_d[way][s] = 1;
`else
      push_wr(a, wd);
`endif
    end else rd = m_blk[way][s][w];
    m_lru[s] = (way == 0);
  endtask
  task automatic do_op(input logic we, input logic [9:0] a, input logic [31:0] wd);
    logic [31:0] e_rd;
    logic e_hit, done;
    int n;
    model(we, a, wd, e_rd, e_hit);
    @(posedge clk);
    #1;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = wd;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk);
      n++;
      #1;
      done = cpu_ready;
    end
    cpu_req = 1'b0;
    r_lat = n;
    r_rdata = cpu_rdata;
    r_hit = cpu_hit;
    check("ready", done, 1'b1);
    if (!we) check("rdata", cpu_rdata, e_rd);
    check("hit", cpu_hit, e_hit);
    if (!we && e_hit) check("latency", n, 3);
    check("ntxn", got_q.size(), exp_q.size());
    last_txn = got_q;
    while (got_q.size() > 0 && exp_q.size() > 0) check("txn", got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    for (int k = 0; k < 256; k++) begin
      mem[k] = k;
      ref_mem[k] = k;
    end
    rst_n = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    rsp_en = 1'b1;
    force_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {cpu_ready, cpu_hit, mem_req, mem_we}, 4'b0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_maddr", {mem_addr, mem_wmask}, 14'd0);
    check("rst_mwdata", mem_wdata, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 10'h010, 32'd0);
    check("r010_rd", r_rdata, 32'd4);
    check("r010_hit", r_hit, 1'b0);
    check("r010_n", last_txn.size(), 1);
    if (last_txn.size() > 0) check("r010_txn", {last_txn[0].we, last_txn[0].addr}, {1'b0, 10'h010});
    do_op(1'b0, 10'h014, 32'd0);
    check("r014_rd", r_rdata, 32'd5);
    check("r014_hit", r_hit, 1'b1);
    check("r014_lat", r_lat, 3);
    check("r014_n", last_txn.size(), 0);
`ifdef CACHE_WRITE_BACK_EN
    do_op(1'b1, 10'h018, 32'd100);
    check("w018_hit", r_hit, 1'b1);
    check("w018_n", last_txn.size(), 0);
    do_op(1'b0, 10'h018, 32'd0);
    check("r018_rd", r_rdata, 32'd100);
    do_op(1'b0, 10'h030, 32'd0);
    do_op(1'b0, 10'h050, 32'd0);
    check("r050_rd", r_rdata, 32'd20);
    check("r050_n", last_txn.size(), 2);
    if (last_txn.size() == 2) begin
      check("evict_wr", {last_txn[0].we, last_txn[0].addr, last_txn[0].mask}, {1'b1, 10'h010, 4'hf});
      check("evict_w2", last_txn[0].data[95:64], 32'd100);
      check("fill050", {last_txn[1].we, last_txn[1].addr}, {1'b0, 10'h050});
    end
`else
    do_op(1'b1, 10'h074, 32'd7);
    check("w074_hit", r_hit, 1'b0);
    check("w074_n", last_txn.size(), 1);
    if (last_txn.size() > 0) begin
      check("w074_txn", {last_txn[0].we, last_txn[0].addr, last_txn[0].mask}, {1'b1, 10'h070, 4'b0010});
      check("w074_lane", last_txn[0].data[63:32], 32'd7);
    end
    do_op(1'b0, 10'h074, 32'd0);
    check("r074_hit", r_hit, 1'b0);
    check("r074_rd", r_rdata, 32'd7);
`endif
    for (int i = 0; i < 200; i++)
      do_op(1'($urandom_range(0, 1)),
            {5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'b00},
            $urandom);
    pulse_reset();
    rsp_en = 1'b0;
    @(posedge clk);
    #1;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 10'h010;
    n = 0;
    while (!mem_req && n < 20) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("abort_wait", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_req", mem_req, 1'b0);
    check("abort_ready", cpu_ready, 1'b0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    check("late_ack", {mem_req, cpu_ready}, 2'b0);
    rsp_en = 1'b1;
    got_q.delete();
    model_reset();
    do_op(1'b0, 10'h010, 32'd0);
    check("rearm_hit", r_hit, 1'b0);
    check("rearm_n", last_txn.size(), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_ctrl_sa.md
CACHE_CTRL_SA -- requirements
Module: cache_ctrl_sa

Interface
REQ-001 Parameter ADDR_W, default 10, byte address width.
REQ-002 Parameter DATA_W, default 32, word width.
REQ-003 Parameter SETS, default 2, number of sets (power of 2, >=2).
REQ-004 Parameter WORDS, default 4, words per block (power of 2, >=2).
REQ-005 Derived widths: OFF=log2(WORDS)+2, IDX=log2(SETS), TAG=ADDR_W-OFF-IDX.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 cpu_req  in  1  request strobe; address and data held stable until cpu_ready.
REQ-010 cpu_we  in  1  1=write, 0=read.
REQ-011 cpu_addr  in  ADDR_W  byte address; low 2 bits ignored.
REQ-012 cpu_wdata  in  DATA_W  write data.
REQ-013 cpu_ready  out  1  one-cycle completion pulse.
REQ-014 cpu_rdata  out  DATA_W  read data, valid with cpu_ready.
REQ-015 cpu_hit  out  1  1=hit on first lookup, valid with cpu_ready.
REQ-016 mem_req  out  1  memory request, held until mem_ack.
REQ-017 mem_we  out  1  memory write.
REQ-018 mem_addr  out  ADDR_W  block-aligned address (low OFF bits zero).
REQ-019 mem_wmask  out  WORDS  per-word write enable.
REQ-020 mem_wdata  out  WORDS*DATA_W  block write data, word 0 in LSBs.
REQ-021 mem_rdata  in  WORDS*DATA_W  block read data, valid with mem_ack.
REQ-022 mem_ack  in  1  one-cycle completion from memory.

Function
REQ-023 Organisation: 2-way set-associative, SETS sets, per-way valid, tag, block; per-set 1-bit LRU pointing at the way to replace.
REQ-024 States: IDLE, COMPARE, WRITEBACK, ALLOCATE, WTHRU, RESPOND; all registered outputs.
REQ-025 IDLE: cpu_req=1 latches addr/we/wdata, clears first-lookup flag, goes COMPARE; cpu_req ignored in any other state.
REQ-026 COMPARE hit: read selects word; write updates word; LRU set to other way; -> RESPOND (or WTHRU, see REQ-035).
REQ-027 COMPARE miss: victim = way0 if both invalid, else an invalid way, else LRU way; victim valid and dirty -> WRITEBACK, otherwise -> ALLOCATE; cpu_hit result becomes 0.
REQ-028 WRITEBACK: mem_req=1, mem_we=1, mem_wmask all ones, mem_addr={victim tag, index, 0}; on mem_ack -> ALLOCATE.
REQ-029 ALLOCATE: mem_req=1, mem_we=0, mem_addr block of latched addr; on mem_ack fill victim, valid=1, dirty=0, -> COMPARE (guaranteed hit).
REQ-030 RESPOND: cpu_ready=1 for exactly one cycle -> IDLE; hit latency 3 cycles from cpu_req sample edge.
REQ-031 mem_req deasserts the cycle after mem_ack is sampled; mem_ack outside WRITEBACK/ALLOCATE/WTHRU ignored.
REQ-032 Tag compare only against valid ways; simultaneous match in both ways cannot occur.

Reset
REQ-033 rst_n low: state IDLE; all valid, dirty, LRU bits 0; cpu_ready, cpu_hit, mem_req, mem_we 0; cpu_rdata, mem_addr, mem_wmask, mem_wdata 0; block data not cleared.
REQ-034 Reset mid-transfer abandons it immediately; late mem_ack after reset ignored.

Configuration
REQ-035 Macro CACHE_WRITE_BACK_EN defined: write-back, write-allocate, per-line dirty bit set on write hit, WTHRU unused. Undefined: write-through no-allocate, no dirty bits, WRITEBACK unused; write hit updates cache then WTHRU; write miss goes straight to WTHRU without allocation; WTHRU issues mem_we=1 with one-hot mem_wmask for the word, word data in its lane, then RESPOND on mem_ack.

Verification (memory model word k initialised to k; default parameters)
REQ-036 Reset, read 0x010 -> one mem read at 0x010, cpu_rdata=4, cpu_hit=0; then read 0x014 -> no mem traffic, cpu_rdata=5, cpu_hit=1, cpu_ready 3 cycles after request.
REQ-037 With macro: write 0x018 data 100 after REQ-036 -> cpu_hit=1, no mem traffic; read 0x018 -> 100.
REQ-038 With macro: read 0x030 then 0x050 (set 1, third tag) -> 0x050 evicts 0x010 line: mem write 0x010 with word2=100, then mem read 0x050, cpu_rdata=20.
REQ-039 Without macro: write miss 0x074 data 7 -> one mem write addr 0x070, mem_wmask=0010, no allocate; read 0x074 -> miss, cpu_rdata=7.
REQ-040 rst_n low while ALLOCATE waits for mem_ack -> mem_req 0 immediately; after release read 0x010 -> miss again.
